// File: rtl/fp_accumulate.sv
// fp_accumulate: single-precision running-sum accumulator.
// Each accepted operand makes one pass through ALIGN -> ADD -> NORM -> ROUND,
// so a new operand can be taken every 5 cycles. Operands with a zero
// exponent (zeros, denormals) count as +0. Inf and NaN get no special treatment.
// The datapath is 27 bits wide: {hidden 1, 23-bit fraction, guard, round, sticky}.

module fp_accumulate #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic [31:0]      acc_out,
    output logic             out_valid,
    output logic             overflow,
    output logic             underflow,
    output logic [CNT_W-1:0] term_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND
    } state_t;

    state_t state, state_nxt;
    logic   transfer;

    // Operand latched on transfer; later changes on in_data are ignored.
    logic [31:0] op_b;

    // ALIGN results: A is the operand with the larger magnitude.
    logic        a_sign;
    logic [7:0]  a_exp;
    logic [26:0] a_mant;
    logic [26:0] b_mant;
    logic        eff_sub;

    // ADD result, including the carry-out bit.
    logic [27:0] sum;
    logic [27:0] sum_nxt;

    // NORM results.
    logic              n_sign;
    logic signed [9:0] n_exp;
    logic [26:0]       n_mant;
    logic              n_zero;

    // Combinational signals for the alignment stage.
    logic        x_zero, y_zero, x_sign, y_sign, swap;
    logic [30:0] x_mag, y_mag;
    logic [26:0] x_mant, y_mant;
    logic        big_sign, small_sign;
    logic [7:0]  big_exp, small_exp, exp_diff;
    logic [26:0] big_mant, small_mant, shifted, b_aligned;
    logic        lost;

    // Combinational signals for the normalisation stage.
    logic [4:0]        lz;
    logic [26:0]       norm_mant;
    logic signed [9:0] norm_exp;

    // Combinational signals for the rounding stage.
    logic              round_up;
    logic [24:0]       rnd_sum;
    logic [22:0]       rnd_frac;
    logic signed [9:0] rnd_exp;
    logic [31:0]       rnd_result;
    logic              rnd_ovf, rnd_unf;

    // Returns the leading-zero count of a 27-bit value (27 when the value is all zeros).
    function automatic logic [4:0] clz27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        transfer  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (!clear && in_valid) begin
                    transfer  = 1'b1;
                    state_nxt = S_ALIGN;
                end
            end
            S_ALIGN: state_nxt = S_ADD;
            S_ADD:   state_nxt = S_NORM;
            S_NORM:  state_nxt = S_ROUND;
            S_ROUND: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments, so every flop samples the values from before the clock edge.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Align: order the running sum and the operand by magnitude, then shift the smaller one right into the GRS datapath.
    always_comb begin
        x_zero = (acc_out[30:23] == 8'd0);
        y_zero = (op_b[30:23] == 8'd0);
        x_mag  = x_zero ? 31'd0 : acc_out[30:0];
        y_mag  = y_zero ? 31'd0 : op_b[30:0];
        x_mant = x_zero ? 27'd0 : {1'b1, acc_out[22:0], 3'b000};
        y_mant = y_zero ? 27'd0 : {1'b1, op_b[22:0], 3'b000};
        x_sign = acc_out[31] & ~x_zero;
        y_sign = op_b[31] & ~y_zero;
        swap   = (y_mag > x_mag);

        if (swap) begin
            big_sign   = y_sign;
            big_exp    = op_b[30:23];
            big_mant   = y_mant;
            small_sign = x_sign;
            small_exp  = acc_out[30:23];
            small_mant = x_mant;
        end else begin
            big_sign   = x_sign;
            big_exp    = acc_out[30:23];
            big_mant   = x_mant;
            small_sign = y_sign;
            small_exp  = op_b[30:23];
            small_mant = y_mant;
        end

        // A zero small operand has exponent 0 and mantissa 0, so the shift amount does not matter.
        exp_diff = big_exp - small_exp;
        if (exp_diff >= 8'd27) begin
            shifted = 27'd0;
            lost    = |small_mant;
        end else begin
            shifted = small_mant >> exp_diff;
            lost    = |(small_mant & ~({27{1'b1}} << exp_diff));
        end
        b_aligned = {shifted[26:1], shifted[0] | lost};
    end

    // Add: A is never smaller than B, so the difference cannot go negative.
    assign sum_nxt = eff_sub ? ({1'b0, a_mant} - {1'b0, b_mant})
                             : ({1'b0, a_mant} + {1'b0, b_mant});

    // Normalise: on a carry, shift right by one and fold the lost bit into sticky; otherwise shift left by the leading-zero count.
    always_comb begin
        lz = clz27(sum[26:0]);
        if (sum[27]) begin
            norm_mant = {sum[27:2], sum[1] | sum[0]};
            norm_exp  = $signed({2'b00, a_exp}) + 10'sd1;
        end else begin
            norm_mant = sum[26:0] << lz;
            norm_exp  = $signed({2'b00, a_exp}) - $signed({5'b00000, lz});
        end
    end

    // Round to nearest even, then saturate on overflow or flush to +0 on underflow.
    always_comb begin
        round_up = n_mant[2] & (n_mant[1] | n_mant[0] | n_mant[3]);
        rnd_sum  = {1'b0, n_mant[26:3]} + {24'd0, round_up};
        if (rnd_sum[24]) begin
            rnd_frac = rnd_sum[23:1];
            rnd_exp  = n_exp + 10'sd1;
        end else begin
            rnd_frac = rnd_sum[22:0];
            rnd_exp  = n_exp;
        end

        rnd_ovf    = 1'b0;
        rnd_unf    = 1'b0;
        rnd_result = 32'd0;
        if (n_zero) begin
            rnd_result = 32'd0;
        end else if (rnd_exp > 10'sd254) begin
            rnd_ovf    = 1'b1;
            rnd_result = {n_sign, 8'hFE, 23'h7FFFFF};
        end else if (rnd_exp < 10'sd1) begin
            rnd_unf    = 1'b1;
            rnd_result = 32'd0;
        end else begin
            rnd_result = {n_sign, rnd_exp[7:0], rnd_frac};
        end
    end

    // Stage registers and the architectural outputs, each loaded in its own FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_b      <= 32'd0;
            a_sign    <= 1'b0;
            a_exp     <= 8'd0;
            a_mant    <= 27'd0;
            b_mant    <= 27'd0;
            eff_sub   <= 1'b0;
            sum       <= 28'd0;
            n_sign    <= 1'b0;
            n_exp     <= 10'sd0;
            n_mant    <= 27'd0;
            n_zero    <= 1'b1;
            acc_out   <= 32'd0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            term_cnt  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        acc_out   <= 32'd0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        term_cnt  <= '0;
                    end else if (transfer) begin
                        op_b <= in_data;
                        if (term_cnt != {CNT_W{1'b1}}) begin
                            term_cnt <= term_cnt + CNT_W'(1);
                        end
                    end
                end
                S_ALIGN: begin
                    a_sign  <= big_sign;
                    a_exp   <= big_exp;
                    a_mant  <= big_mant;
                    b_mant  <= b_aligned;
                    eff_sub <= big_sign ^ small_sign;
                end
                S_ADD: begin
                    sum <= sum_nxt;
                end
                S_NORM: begin
                    n_sign <= a_sign;
                    n_exp  <= norm_exp;
                    n_mant <= norm_mant;
                    n_zero <= (sum == 28'd0);
                end
                S_ROUND: begin
                    acc_out   <= rnd_result;
                    out_valid <= 1'b1;
                    overflow  <= overflow | rnd_ovf;
                    underflow <= underflow | rnd_unf;
                end
                default: ;
            endcase
        end
    end

endmodule
